ring_host: RTL and testbench
============================

# ring_host

Tester-side endpoint for the serial layer ring: it accepts a block of parallel words, serializes them as one frame into the ring's first-layer `data_in`, and waits until every layer reports `sort_finish`. It then deserializes the frame returning on the ring's last-layer `data_out` and hands the words back through a valid/ready stream. It sits between the test controller and the chained layer tops, and is the transmitter and receiver counterpart to the layers' serial ports.

## Interface
- `WIDTH`, 8, bits per word.
- `WORDS`, 4, words per frame.
- `LAYERS`, 2, number of `sort_finish` inputs.
- `TIMEOUT`, 1024, maximum cycles spent in WAIT plus start-bit hunt.

Ports:
- `t_clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in WIDTH: word to send.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: a word is accepted when `s_valid` and `s_ready` are both high.
- `ring_out` out 1: serial stream to the ring input (first layer `data_in`).
- `ring_in` in 1: serial stream from the ring output (last layer `data_out`).
- `sort_finish` in LAYERS: per-layer completion flags.
- `m_data` out WIDTH: returned word.
- `m_valid` out 1: `m_data` is valid; held until `m_ready`.
- `m_ready` in 1: consumer accepts the word.
- `busy` out 1: high in any state except IDLE.
- `err_timeout` out 1: sticky timeout flag; exists only with the macro defined.

## Operation
- **Frame format:**
  - Idle line is 0.
  - One start bit of value 1.
  - Then WORDS×WIDTH data bits: word 0 first, MSB first.
- **States:** IDLE, LOAD, SEND, WAIT, HUNT, RECV, OUT.
- **IDLE/LOAD:**
  - `s_ready` = 1.
  - Each handshake stores a word at index `wcnt` and increments `wcnt`.
  - The first handshake moves IDLE to LOAD.
  - The handshake on word WORDS-1 moves to SEND and drops `s_ready` in the same cycle it is registered.
- **SEND:**
  - Cycle 0 drives `ring_out` = 1 (start bit).
  - Cycles 1..WORDS×WIDTH drive the data bits, using a bit counter of width clog2(WORDS×WIDTH+1).
  - After the last bit, go to WAIT. `ring_out` returns to 0.
- **WAIT:**
  - Stay until `&sort_finish` = 1, then go to HUNT.
  - If `sort_finish` is already all-ones on entry, leave after exactly one cycle.
- **HUNT:**
  - Sample `ring_in` each cycle.
  - The first 1 is the start bit; go to RECV.
- **RECV:**
  - Shift in WORDS×WIDTH bits, MSB first, into the word buffer (the same buffer used by LOAD).
  - Then go to OUT.
- **OUT:**
  - Present word `rcnt` with `m_valid` = 1; `m_data` is stable while `m_valid` is high and `m_ready` is low.
  - A handshake on word WORDS-1 returns to IDLE.
- **Simultaneous events:** `s_valid` is ignored outside IDLE/LOAD, and `ring_in` is ignored outside HUNT/RECV.

## Timing
- **Reset values:**
  - `s_ready` 0 during reset, 1 from the first cycle after reset.
  - `ring_out` 0, `m_valid` 0, `m_data` 0, `busy` 0, `err_timeout` 0.
  - State IDLE, all counters 0.
- **Send latency:** the start bit appears on `ring_out` in the cycle after the last LOAD handshake. SEND lasts 1+WORDS×WIDTH cycles.
- **Receive:** `ring_in` is registered directly, with no sync stage (same clock domain). The first RECV data bit is the cycle after the start bit.
- **Output:** `m_valid` rises in the cycle after the last RECV bit. One word per cycle at full throughput.
- **Reset mid-operation:** aborts any state. `ring_out` is 0 and `m_valid` is 0 in the next cycle, and partial data is discarded.
- **Registered outputs:** all outputs are registered; there are no combinational paths from input to output.

## Configuration
- **Macro `RING_HOST_TIMEOUT_EN`:**
  - **Defined:**
    - A counter runs in WAIT and HUNT.
    - Reaching TIMEOUT cycles forces IDLE and sets `err_timeout`.
    - `err_timeout` stays set until the next accepted `s_valid` handshake, or until reset.
  - **Undefined:**
    - No counter.
    - WAIT and HUNT may last indefinitely.
    - The `err_timeout` port is absent.

## Structure
- **Shared package `ring_pkg`:** state enum `ring_state_t`, the start-bit constant, and the idle-level constant. Layer tops use the same package.
- **Sub-module `ring_shift`:** a WORDS×WIDTH shift register with parallel word write/read by index and serial shift-in/shift-out. It is shared by SEND and RECV. The FSM and counters stay in `ring_host`.

## Test plan
- **Frame encoding:** WIDTH=8, WORDS=4; load A5,3C,FF,00. Required: `ring_out` = 1, then 10100101 00111100 11111111 00000000, then 0. `busy` is high from the first handshake.
- **Loopback:** `ring_out` wired to `ring_in` through a 5-cycle delay, `sort_finish` = 2'b11. Required: `m_data` returns A5,3C,FF,00 in order.
- **Backpressure:** `m_ready` toggles 1010. Required: each word is held stable while stalled, there is no duplicate or skip, and the state returns to IDLE after the 4th handshake.
- **Wait gating:** `sort_finish` = 01 for 50 cycles, then 11; a frame is injected on `ring_in` during the 01 period. Required: that frame is ignored, and the later frame is captured.
- **Timeout (macro defined):** TIMEOUT=16, `sort_finish` = 00. Required: IDLE after 16 WAIT cycles, `err_timeout` = 1, and cleared on the next accepted `s_valid`.
- **Reset mid-SEND:** assert `rst` at bit 10. Required: `ring_out` = 0 the next cycle, all outputs at reset values, and a fresh frame works afterwards.

Source files
------------

// File: rtl/ring_pkg.sv
// ring_pkg: definitions shared by ring_host and the layer tops of the serial ring.
//   ring_state_t : FSM state encoding of the ring host
//   START_BIT    : level of the single bit that opens a frame
//   IDLE_LEVEL   : level driven on the ring line between frames
package ring_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_HUNT = 3'd4,
    ST_RECV = 3'd5,
    ST_OUT  = 3'd6
  } ring_state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/ring_shift.sv
// ring_shift: WORDS x WIDTH frame buffer shared by transmit and receive.
// Word 0 sits in the most significant bits so a left shift emits/accepts the
// frame word 0 first, MSB first.
// Ports:
//   t_clk, rst      : clock, synchronous active-high reset (clears the buffer)
//   i_wr_en/idx/data: parallel write of one word
//   i_rd_idx        : word index for o_rd_word
//   o_rd_word       : word at i_rd_idx (combinational read of the buffer)
//   i_shift_en/in   : shift the whole buffer left by one, i_shift_in enters at the LSB
//   o_shift_msb     : bit leaving the buffer on the next shift
//   o_next_word0    : word 0 as it will look after the next shift
module ring_shift #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 4,
  localparam int unsigned IW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             t_clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [IW-1:0]    i_wr_idx,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [IW-1:0]    i_rd_idx,
  output logic [WIDTH-1:0] o_rd_word,
  input  logic             i_shift_en,
  input  logic             i_shift_in,
  output logic             o_shift_msb,
  output logic [WIDTH-1:0] o_next_word0
);

  localparam int unsigned N = WORDS * WIDTH;

  logic [N-1:0] r_q;
  logic [N-1:0] w_shifted;

  assign w_shifted    = {r_q[N-2:0], i_shift_in};
  assign o_shift_msb  = r_q[N-1];
  assign o_next_word0 = w_shifted[N-1 -: WIDTH];

  // Buffer update: serial shift has priority over a parallel word write.
  always_ff @(posedge t_clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_shift_en) begin
      r_q <= w_shifted;
    end else if (i_wr_en) begin
      for (int k = 0; k < int'(WORDS); k++) begin
        if (IW'(k) == i_wr_idx) r_q[N-1-k*WIDTH -: WIDTH] <= i_wr_data;
      end
    end
  end

  // Word read mux.
  always_comb begin
    o_rd_word = '0;
    for (int k = 0; k < int'(WORDS); k++) begin
      if (IW'(k) == i_rd_idx) o_rd_word = r_q[N-1-k*WIDTH -: WIDTH];
    end
  end

endmodule

// File: rtl/ring_host.sv
// ring_host: tester-side endpoint of the serial layer ring. Collects WORDS
// words, sends them as one frame (start bit, then word 0 first, MSB first)
// on ring_out, waits for every layer's sort_finish, hunts for the returning
// frame's start bit on ring_in, captures it and streams the words back out.
// Optional feature macro: RING_HOST_TIMEOUT_EN adds a WAIT+HUNT cycle limit
// and the sticky err_timeout output.
// Ports:
//   t_clk, rst            : clock, synchronous active-high reset
//   s_data/s_valid/s_ready: input word stream
//   ring_out / ring_in    : serial line to the first layer / from the last layer
//   sort_finish           : per-layer completion flags
//   m_data/m_valid/m_ready: returned word stream
//   busy                  : high whenever not idle
//   err_timeout           : sticky timeout flag (macro builds only)
module ring_host
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned LAYERS  = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              t_clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ring_out,
  input  logic              ring_in,
  input  logic [LAYERS-1:0] sort_finish,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy
`ifdef RING_HOST_TIMEOUT_EN
  ,
  output logic              err_timeout
`endif
);

  localparam int unsigned N  = WORDS * WIDTH;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned BW = $clog2(N + 1);

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("ring_host: TIMEOUT must be at least 1");
  end

  ring_state_t      r_state, w_next;
  logic [IW-1:0]    r_wcnt, r_ocnt, w_rd_idx;
  logic [BW-1:0]    r_bcnt;
  logic             r_s_ready, r_ring_out, r_m_valid, r_busy;
  logic [WIDTH-1:0] r_m_data;
  logic             w_s_hs, w_m_hs, w_wr_en, w_shift_en, w_shift_in, w_msb;
  logic [WIDTH-1:0] w_rd_word, w_next_word0;

`ifdef RING_HOST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_err, w_timeout;
  assign err_timeout = r_err;
`endif

  assign s_ready  = r_s_ready;
  assign ring_out = r_ring_out;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign busy     = r_busy;

  // s_ready is only high in IDLE/LOAD, so s_valid is ignored everywhere else.
  assign w_s_hs     = r_s_ready & s_valid;
  assign w_m_hs     = r_m_valid & m_ready;
  assign w_rd_idx   = r_ocnt + IW'(1);
  assign w_shift_in = (r_state == ST_RECV) ? ring_in : IDLE_LEVEL;

  ring_shift #(
    .WIDTH(WIDTH),
    .WORDS(WORDS)
  ) u_shift (
    .t_clk       (t_clk),
    .rst         (rst),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (r_wcnt),
    .i_wr_data   (s_data),
    .i_rd_idx    (w_rd_idx),
    .o_rd_word   (w_rd_word),
    .i_shift_en  (w_shift_en),
    .i_shift_in  (w_shift_in),
    .o_shift_msb (w_msb),
    .o_next_word0(w_next_word0)
  );

  // Next-state and buffer control.
  always_comb begin
    w_next     = r_state;
    w_wr_en    = 1'b0;
    w_shift_en = 1'b0;
`ifdef RING_HOST_TIMEOUT_EN
    w_timeout  = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_s_hs) begin
          w_wr_en = 1'b1;
          w_next  = (r_wcnt == IW'(WORDS - 1)) ? ST_SEND : ST_LOAD;
        end
      end
      // bcnt 0 shows the start bit; each shift loads the next data bit into ring_out.
      ST_SEND: begin
        if (r_bcnt < BW'(N)) w_shift_en = 1'b1;
        else                 w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (&sort_finish) w_next = ST_HUNT;
`ifdef RING_HOST_TIMEOUT_EN
        else if (r_tcnt >= TW'(TIMEOUT - 1)) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
`endif
      end
      ST_HUNT: begin
        if (ring_in == START_BIT) w_next = ST_RECV;
`ifdef RING_HOST_TIMEOUT_EN
        else if (r_tcnt >= TW'(TIMEOUT - 1)) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
`endif
      end
      ST_RECV: begin
        w_shift_en = 1'b1;
        if (r_bcnt == BW'(N - 1)) w_next = ST_OUT;
      end
      ST_OUT: begin
        if (w_m_hs && (r_ocnt == IW'(WORDS - 1))) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge t_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wcnt     <= '0;
      r_ocnt     <= '0;
      r_bcnt     <= '0;
      r_s_ready  <= 1'b0;
      r_ring_out <= IDLE_LEVEL;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_s_ready <= (w_next == ST_IDLE) || (w_next == ST_LOAD);
      r_busy    <= (w_next != ST_IDLE);

      if (w_wr_en) r_wcnt <= (w_next == ST_SEND) ? '0 : r_wcnt + IW'(1);

      if (w_next != r_state)                             r_bcnt <= '0;
      else if (r_state == ST_SEND || r_state == ST_RECV) r_bcnt <= r_bcnt + BW'(1);

      if (r_state != ST_SEND && w_next == ST_SEND)      r_ring_out <= START_BIT;
      else if (r_state == ST_SEND && w_next == ST_SEND) r_ring_out <= w_msb;
      else                                              r_ring_out <= IDLE_LEVEL;

      // Word 0 is taken from the post-shift view so m_valid rises right after the last bit.
      if (r_state == ST_RECV && w_next == ST_OUT) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_next_word0;
        r_ocnt    <= '0;
      end else if (r_state == ST_OUT && w_m_hs) begin
        if (w_next == ST_IDLE) begin
          r_m_valid <= 1'b0;
          r_ocnt    <= '0;
        end else begin
          r_m_data <= w_rd_word;
          r_ocnt   <= w_rd_idx;
        end
      end
    end
  end

`ifdef RING_HOST_TIMEOUT_EN
  // Timeout budget covers WAIT and HUNT together; cleared on any other state.
  always_ff @(posedge t_clk) begin
    if (rst) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state == ST_WAIT || r_state == ST_HUNT) &&
          (w_next == ST_WAIT || w_next == ST_HUNT)) r_tcnt <= r_tcnt + TW'(1);
      else                                          r_tcnt <= '0;

      if (w_timeout)   r_err <= 1'b1;
      else if (w_s_hs) r_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ring_host.sv
// tb_ring_host: self-checking bench for ring_host. The ring is modelled as a
// pure delay line (frame length plus 5 cycles) so the frame has fully left
// the host before it returns; expected serial bits and returned words are
// computed from the frame format directly.
module tb_ring_host;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned LAYERS = 2;
  localparam int unsigned N      = WIDTH * WORDS;
  localparam int unsigned LB     = N + 1 + 5;

  typedef logic [WIDTH-1:0] frame_t [WORDS];

  logic              t_clk = 1'b0;
  logic              rst   = 1'b1;
  logic [WIDTH-1:0]  s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              ring_out;
  logic              ring_in;
  logic [LAYERS-1:0] sort_finish = '0;
  logic [WIDTH-1:0]  m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              busy;

  logic          lb_en   = 1'b0;
  logic          inj_bit = 1'b0;
  logic [LB-1:0] pipe    = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 t_clk = ~t_clk;

  always @(posedge t_clk) pipe <= lb_en ? {pipe[LB-2:0], ring_out} : '0;
  assign ring_in = lb_en ? pipe[LB-1] : inj_bit;

`ifdef RING_HOST_TIMEOUT_EN
  logic             err_main, s_ready_to, ring_out_to, m_valid_to, busy_to, err_to;
  logic [WIDTH-1:0] m_data_to;

  ring_host #(.WIDTH(WIDTH), .WORDS(WORDS), .LAYERS(LAYERS), .TIMEOUT(16)) dut_to (
    .t_clk(t_clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_to),
    .ring_out(ring_out_to), .ring_in(ring_in), .sort_finish(sort_finish),
    .m_data(m_data_to), .m_valid(m_valid_to), .m_ready(m_ready), .busy(busy_to),
    .err_timeout(err_to)
  );
`endif

  ring_host #(.WIDTH(WIDTH), .WORDS(WORDS), .LAYERS(LAYERS), .TIMEOUT(1024)) dut (
    .t_clk(t_clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ring_out(ring_out), .ring_in(ring_in), .sort_finish(sort_finish),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
`ifdef RING_HOST_TIMEOUT_EN
    , .err_timeout(err_main)
`endif
  );

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    foreach (f[i]) f[i] = WIDTH'($urandom);
    return f;
  endfunction

  // Serial bit i of a frame's data field: word i/WIDTH, MSB first.
  function automatic logic frame_bit(input frame_t w, input int i);
    logic [WIDTH-1:0] word;
    word = w[i / int'(WIDTH)];
    return word[int'(WIDTH) - 1 - (i % int'(WIDTH))];
  endfunction

  // Feeds the words; ends in the first SEND cycle (start bit on ring_out).
  task automatic load_frame(input frame_t w, input bit gaps);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    while (i < int'(WORDS) && guard < 200) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = s_valid ? w[i] : WIDTH'($urandom);
      acc     = s_valid && s_ready;
      tick();
      guard++;
      if (acc) begin
        i++;
        if (i == 1) begin
          n_checks++;
          if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_busy: busy=%b expected 1", busy);
          end
        end
      end
    end
    s_valid = 1'b0;
    n_checks++;
    if (i != int'(WORDS)) begin
      n_fail++;
      $display("FAIL load_budget: accepted %0d words expected %0d", i, WORDS);
    end
    n_checks++;
    if (s_ready !== 1'b0 || ring_out !== 1'b1) begin
      n_fail++;
      $display("FAIL load_to_send: s_ready=%b ring_out=%b expected 0/1", s_ready, ring_out);
    end
  endtask

  // Checks the data bits and the return to idle level after the frame.
  task automatic send_check(input frame_t w);
    for (int k = 1; k <= int'(N); k++) begin
      tick();
      n_checks++;
      if (ring_out !== frame_bit(w, k - 1)) begin
        n_fail++;
        $display("FAIL send_bit%0d: ring_out=%b expected %b", k - 1, ring_out, frame_bit(w, k - 1));
      end
    end
    tick();
    n_checks++;
    if (ring_out !== 1'b0) begin
      n_fail++;
      $display("FAIL send_idle: ring_out=%b expected 0", ring_out);
    end
  endtask

  // mode 0: always ready, 1: toggle 1010.., 2: random.
  task automatic receive_frame(input frame_t w, input int mode);
    int guard = 0;
    int idx = 0;
    int cyc = 0;
    bit hs;
    m_ready = 1'b0;
    while (m_valid !== 1'b1 && guard < 400) begin
      tick();
      guard++;
    end
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL recv_wait: m_valid=%b expected 1 within 400 cycles", m_valid);
    end
    while (idx < int'(WORDS) && cyc < 200) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== w[idx]) begin
        n_fail++;
        $display("FAIL recv_word%0d: m_valid=%b m_data=%h expected 1/%h", idx, m_valid, m_data, w[idx]);
      end
      hs = m_ready;
      tick();
      cyc++;
      if (hs) idx++;
    end
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL recv_idle: m_valid=%b busy=%b s_ready=%b expected 0/0/1", m_valid, busy, s_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (s_ready !== 1'b0 || ring_out !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: s_ready=%b ring_out=%b m_valid=%b m_data=%h busy=%b expected all 0",
               s_ready, ring_out, m_valid, m_data, busy);
    end
`ifdef RING_HOST_TIMEOUT_EN
    n_checks++;
    if (err_main !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: err_timeout=%b expected 0", err_main);
    end
`endif
    rst = 1'b0;
    tick();
    n_checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: s_ready=%b busy=%b expected 1/0", s_ready, busy);
    end
  endtask

  task automatic test_frame_encoding();
    frame_t w;
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'hFF; w[3] = 8'h00;
    lb_en = 1'b1;
    sort_finish = 2'b11;
    load_frame(w, 1'b0);
    send_check(w);
    // Now in cycle N+1 counted from the start bit; m_valid due at LB+N+1.
    for (int c = int'(N) + 2; c <= int'(LB + N); c++) tick();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL recv_early: m_valid=%b expected 0", m_valid);
    end
    tick();
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL recv_latency: m_valid=%b expected 1", m_valid);
    end
    receive_frame(w, 0);
  endtask

  task automatic test_backpressure();
    frame_t w = rand_frame();
    lb_en = 1'b1;
    sort_finish = 2'b11;
    load_frame(w, 1'b0);
    receive_frame(w, 1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      frame_t w = rand_frame();
      lb_en = 1'b1;
      sort_finish = 2'b11;
      load_frame(w, 1'b1);
      receive_frame(w, 2);
    end
  endtask

  task automatic test_wait_gating();
    frame_t w1 = rand_frame();
    frame_t bogus = rand_frame();
    frame_t w2 = rand_frame();
    lb_en = 1'b0;
    inj_bit = 1'b0;
    sort_finish = 2'b01;
    load_frame(w1, 1'b0);
    for (int c = 0; c <= int'(N); c++) tick();
    for (int c = 0; c < 50; c++) begin
      if (c == 5)                          inj_bit = 1'b1;
      else if (c > 5 && c <= 5 + int'(N))  inj_bit = frame_bit(bogus, c - 6);
      else                                 inj_bit = 1'b0;
      tick();
    end
    inj_bit = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_hold: busy=%b m_valid=%b expected 1/0", busy, m_valid);
    end
    sort_finish = 2'b11;
    for (int c = 0; c < 3; c++) tick();
    inj_bit = 1'b1;
    tick();
    for (int k = 0; k < int'(N); k++) begin
      inj_bit = frame_bit(w2, k);
      tick();
    end
    inj_bit = 1'b0;
    receive_frame(w2, 2);
  endtask

  task automatic test_reset_mid_send();
    frame_t w = rand_frame();
    frame_t f = rand_frame();
    lb_en = 1'b0;
    sort_finish = 2'b11;
    load_frame(w, 1'b0);
    for (int c = 0; c < 10; c++) tick();
    n_checks++;
    if (ring_out !== frame_bit(w, 9)) begin
      n_fail++;
      $display("FAIL mid_send_bit: ring_out=%b expected %b", ring_out, frame_bit(w, 9));
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (ring_out !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL mid_send_reset: ring_out=%b m_valid=%b busy=%b s_ready=%b m_data=%h expected 0",
               ring_out, m_valid, busy, s_ready, m_data);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (s_ready !== 1'b1 || ring_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_send_release: s_ready=%b ring_out=%b expected 1/0", s_ready, ring_out);
    end
    lb_en = 1'b1;
    load_frame(f, 1'b0);
    send_check(f);
    receive_frame(f, 0);
  endtask

`ifdef RING_HOST_TIMEOUT_EN
  task automatic test_timeout();
    frame_t w = rand_frame();
    lb_en = 1'b0;
    inj_bit = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    sort_finish = 2'b00;
    load_frame(w, 1'b0);
    for (int c = 0; c <= int'(N); c++) tick();
    for (int c = 0; c < 15; c++) tick();
    n_checks++;
    if (busy_to !== 1'b1 || err_to !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: busy=%b err=%b expected 1/0", busy_to, err_to);
    end
    tick();
    n_checks++;
    if (busy_to !== 1'b0 || err_to !== 1'b1 || s_ready_to !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fire: busy=%b err=%b s_ready=%b expected 0/1/1", busy_to, err_to, s_ready_to);
    end
    for (int c = 0; c < 3; c++) tick();
    n_checks++;
    if (err_to !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: err=%b expected 1", err_to);
    end
    s_valid = 1'b1;
    s_data  = w[0];
    tick();
    s_valid = 1'b0;
    n_checks++;
    if (err_to !== 1'b0 || busy_to !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_clear: err=%b busy=%b expected 0/1", err_to, busy_to);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_encoding();
    test_backpressure();
    test_back_to_back();
    test_wait_gating();
    test_reset_mid_send();
`ifdef RING_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
